serial_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor. It is the sequential successor to the single-bit full adder and uses a CHUNK-bit ripple slice iteratively over a WIDTH-bit operand. Valid/ready handshakes are provided on both input and output, along with carry-out and signed-overflow flags. It serves as the arithmetic core for later datapath labs, where area is traded for latency.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/serial_adder_chunk.sv | 26 ++
 rtl/serial_adder.sv | 126 ++++++++++++
 tb/tb_serial_adder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and elaboration helpers for the multi-cycle serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Chunk-index register width; a single-chunk build still needs one bit.
  function automatic int idx_w(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_chunk.sv
// Combinational CHUNK-bit ripple slice built from full-adder cells.
module adder_chunk #(
  parameter int CHUNK = 1
) (
  input  logic [CHUNK-1:0] a_slice,
  input  logic [CHUNK-1:0] b_slice,
  input  logic             cin,
  output logic [CHUNK-1:0] s_slice,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s_slice[i] = a_slice[i] ^ b_slice[i] ^ c[i];
    assign c[i+1]     = (a_slice[i] & b_slice[i]) | (c[i] & (a_slice[i] ^ b_slice[i]));
  end

  assign cout  = c[CHUNK];
  // Carry into the slice's top bit; only meaningful for the final chunk's overflow.
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, valid/ready on both sides.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = idx_w(NCHUNK);
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_param
    $error("serial_adder: WIDTH must be >= 2 and divisible by CHUNK");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [CHUNK-1:0]  a_sl, b_sl, s_sl;
  logic              c_out, c_msb;

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IW'(i)) begin
        a_sl = a_q[i*CHUNK +: CHUNK];
        b_sl = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a_slice (a_sl),
    .b_slice (b_sl),
    .cin     (carry_q),
    .s_slice (s_sl),
    .cout    (c_out),
    .c_msb   (c_msb)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1, so the mode is folded into the latched operand.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NCHUNK; i++) begin
          if (idx_q == IW'(i)) sum_d[i*CHUNK +: CHUNK] = s_sl;
        end
        carry_d = c_out;
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST) begin
          cout_d  = c_out;
          ovf_d   = c_out ^ c_msb;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder in CHUNK=1, 4 and 8 builds.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic [7:0] a, b;
  logic       cin, sub;
  logic       in_valid_v  [3];
  logic       in_ready_v  [3];
  logic       out_valid_v [3];
  logic       out_ready_v [3];
  logic [7:0] sum_v       [3];
  logic       cout_v      [3];
  logic       ovf_v       [3];

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]));

  serial_adder #(.WIDTH(8), .CHUNK(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]));

  serial_adder #(.WIDTH(8), .CHUNK(8)) u_c8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid_v[2]),
    .out_ready(out_ready_v[2]), .sum(sum_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 9-bit sum; overflow from operand/result sign agreement.
  function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                       input logic mcin, input logic msub);
    logic [7:0] beff;
    logic [8:0] t;
    logic       v;
    beff = msub ? ~mb : mb;
    t    = {1'b0, ma} + {1'b0, beff} + {8'd0, (msub ? 1'b1 : mcin)};
    v    = (ma[7] == beff[7]) && (t[7] != ma[7]);
    return {t[7:0], t[8], v};
  endfunction

  task automatic wait_done(input int u, output int lat, output logic busy_ok);
    lat = 0;
    busy_ok = 1'b1;
    while (!out_valid_v[u] && lat < 50) begin
      if (in_ready_v[u]) busy_ok = 1'b0;
      step();
      lat++;
    end
    if (in_ready_v[u]) busy_ok = 1'b0;
  endtask

  task automatic run_op(input int u, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tcin, input logic tsub, input logic [9:0] exp,
                        input int exp_lat, input string tag);
    int   wt, lat;
    logic busy_ok;
    wt = 0;
    while (!in_ready_v[u] && wt < 20) begin
      step();
      wt++;
    end
    chk({tag, " in_ready_idle"}, 32'(in_ready_v[u]), 32'd1);
    a = ta; b = tb; cin = tcin; sub = tsub;
    in_valid_v[u] = 1'b1;
    step();
    in_valid_v[u] = 1'b0;
    a = ~ta; b = ~tb; cin = ~tcin; sub = ~tsub;
    wait_done(u, lat, busy_ok);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " in_ready_busy"}, 32'(busy_ok), 32'd1);
    chk({tag, " result"}, 32'({sum_v[u], cout_v[u], ovf_v[u]}), 32'(exp));
    out_ready_v[u] = 1'b1;
    step();
    out_ready_v[u] = 1'b0;
    chk({tag, " out_valid_clr"}, 32'(out_valid_v[u]), 32'd0);
  endtask

  initial begin
    int         lat;
    logic       busy_ok;
    logic [7:0] ra, rb;
    logic       rc, rs;

    rst_n = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid_v[i]  = 1'b0;
      out_ready_v[i] = 1'b0;
    end
    step();
    step();
    chk("rst in_ready", 32'(in_ready_v[0]), 32'd1);
    chk("rst out_valid", 32'(out_valid_v[0]), 32'd0);
    chk("rst sum_cout_ovf", 32'({sum_v[0], cout_v[0], ovf_v[0]}), 32'd0);
    rst_n = 1'b1;
    step();

    run_op(0, 8'h00, 8'h00, 1'b0, 1'b0, {8'h00, 1'b0, 1'b0}, 8, "zero");
    run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0, {8'h00, 1'b1, 1'b0}, 8, "ff_plus_1");
    run_op(0, 8'h7F, 8'h00, 1'b1, 1'b0, {8'h80, 1'b0, 1'b1}, 8, "7f_cin");
    run_op(0, 8'h05, 8'h07, 1'b1, 1'b1, {8'hFE, 1'b0, 1'b0}, 8, "sub_5_7");
    run_op(0, 8'h80, 8'h01, 1'b0, 1'b1, {8'h7F, 1'b1, 1'b1}, 8, "sub_80_1");

    // Backpressure: result held, in_valid ignored while DONE.
    a = 8'h3C; b = 8'h0F; cin = 1'b0; sub = 1'b0;
    in_valid_v[0] = 1'b1;
    step();
    in_valid_v[0] = 1'b0;
    wait_done(0, lat, busy_ok);
    chk("bp latency", 32'(lat), 32'd8);
    in_valid_v[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = ~a;
      b = 8'(i * 37);
      step();
      chk("bp held", 32'({sum_v[0], cout_v[0], ovf_v[0]}), 32'({8'h4B, 1'b0, 1'b0}));
      chk("bp in_ready", 32'({in_ready_v[0], out_valid_v[0]}), 32'b01);
    end
    a = 8'h10; b = 8'h20;
    out_ready_v[0] = 1'b1;
    step();
    out_ready_v[0] = 1'b0;
    chk("bp back_idle", 32'({in_ready_v[0], out_valid_v[0]}), 32'b10);
    step();
    in_valid_v[0] = 1'b0;
    chk("bp accepted", 32'(in_ready_v[0]), 32'd0);
    wait_done(0, lat, busy_ok);
    chk("bp next latency", 32'(lat), 32'd8);
    chk("bp next result", 32'({sum_v[0], cout_v[0], ovf_v[0]}), 32'({8'h30, 1'b0, 1'b0}));
    out_ready_v[0] = 1'b1;
    step();
    out_ready_v[0] = 1'b0;

    // Asynchronous reset during RUN after three chunks.
    a = 8'hAA; b = 8'h55; cin = 1'b0; sub = 1'b0;
    in_valid_v[0] = 1'b1;
    step();
    in_valid_v[0] = 1'b0;
    step(); step(); step();
    chk("mid partial sum", 32'(sum_v[0]), 32'h07);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst outputs", 32'({sum_v[0], cout_v[0], ovf_v[0], out_valid_v[0]}), 32'd0);
    chk("async rst in_ready", 32'(in_ready_v[0]), 32'd1);
    rst_n = 1'b1;
    step();
    chk("post rst in_ready", 32'(in_ready_v[0]), 32'd1);
    run_op(0, 8'h12, 8'h34, 1'b0, 1'b0, {8'h46, 1'b0, 1'b0}, 8, "after_rst");

    run_op(1, 8'h7F, 8'h01, 1'b0, 1'b0, {8'h80, 1'b0, 1'b1}, 2, "c4 dir");
    run_op(2, 8'h00, 8'h01, 1'b0, 1'b1, {8'hFF, 1'b0, 1'b0}, 1, "c8 dir");

    for (int u = 1; u < 3; u++) begin
      for (int n = 0; n < 1000; n++) begin
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        rc = 1'($urandom_range(0, 1));
        rs = 1'($urandom_range(0, 1));
        run_op(u, ra, rb, rc, rs, model(ra, rb, rc, rs), (u == 1) ? 2 : 1,
               (u == 1) ? "c4 rand" : "c8 rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
